id_ex_register: RTL

ID/EX pipeline boundary of the five-stage core. Captures the decoded instruction, the register-file read data and the control bundle from the decode-stage control unit, and presents them to the execute stage one cycle later. Contains the load-use hazard detector: it stalls fetch and IF/ID and inserts a bubble. On a taken branch resolved in EX/DM it squashes the instruction entering EX. A saturating counter reports the number of inserted bubbles.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/id_ex_register_if.sv | 47 ++++
 rtl/id_ex_register_hazard_detect.sv | 24 ++
 rtl/id_ex_register.sv | 95 +++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, squash encoding and opcodes.
package pipe_pkg;
    localparam int CTRL_W = 10;

    localparam int CTRL_REG_DST    = 9;
    localparam int CTRL_BRANCH     = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_JUMP       = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    // Same encoding the control unit emits when it squashes an instruction.
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 10'b00_0000_0010;

    localparam logic [5:0] RType = 6'h00;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] JUMP  = 6'h02;
endpackage

// File: rtl/id_ex_register_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX boundary.
interface id_ex_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_W  = 5
);
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [15:0]       id_imm;
    logic [5:0]        id_funct;
    logic [CTRL_W-1:0] id_ctrl;
    logic              branch_out_ex_dm;

    logic              stall_out;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm_ext;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic [5:0]        ex_funct;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [15:0]       bubble_count;

    modport master (
        output id_valid, id_pc, id_rs_data, id_rt_data, id_rs, id_rt, id_rd,
               id_imm, id_funct, id_ctrl, branch_out_ex_dm,
        input  stall_out, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_rs, ex_rt, ex_rd, ex_funct, ex_ctrl, bubble_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs_data, id_rt_data, id_rs, id_rt, id_rd,
               id_imm, id_funct, id_ctrl, branch_out_ex_dm,
        output stall_out, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_rs, ex_rt, ex_rd, ex_funct, ex_ctrl, bubble_count
    );
endinterface

// File: rtl/id_ex_register_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the ID instruction.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_alu_src,
    input  logic             id_mem_write,
    input  logic             id_jump,
    output logic             load_use
);
    logic id_uses_rt;

    always_comb begin
        // rt is a source for R-type, BEQ and SW; never for jumps.
        id_uses_rt = (~id_alu_src | id_mem_write) & ~id_jump;
        load_use   = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end
endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use stall, branch squash and bubble counter.
module id_ex_register
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_W  = 5
) (
    input logic    clk,
    input logic    reset,
    id_ex_if.slave bus
);
    logic              load_use;
    logic              bubble;

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [PC_W-1:0]   ex_pc_q;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rt_data_q, ex_imm_ext_q, ex_imm_ext_d;
    logic [REG_W-1:0]  ex_rs_q, ex_rt_q, ex_rd_q;
    logic [5:0]        ex_funct_q;
    logic [15:0]       bubble_count_q, bubble_count_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_valid     (ex_valid_q),
        .ex_mem_read  (ex_ctrl_q[CTRL_MEM_READ]),
        .ex_rt        (ex_rt_q),
        .id_valid     (bus.id_valid),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_alu_src   (bus.id_ctrl[CTRL_ALU_SRC]),
        .id_mem_write (bus.id_ctrl[CTRL_MEM_WRITE]),
        .id_jump      (bus.id_ctrl[CTRL_JUMP]),
        .load_use     (load_use)
    );

    always_comb begin
        bubble       = 1'b0;
        ex_valid_d   = bus.id_valid;
        ex_ctrl_d    = bus.id_valid ? bus.id_ctrl : BUBBLE_CTRL;
        ex_imm_ext_d = {{(DATA_W-16){bus.id_imm[15]}}, bus.id_imm};
        // Squash and load-use both insert a single bubble; squash has priority.
        if (bus.branch_out_ex_dm || load_use) begin
            bubble     = 1'b1;
            ex_valid_d = 1'b0;
            ex_ctrl_d  = BUBBLE_CTRL;
        end
        bubble_count_d = bubble ? sat_inc(bubble_count_q) : bubble_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= BUBBLE_CTRL;
            ex_pc_q        <= '0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_ext_q   <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_funct_q     <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_pc_q        <= bus.id_pc;
            ex_rs_data_q   <= bus.id_rs_data;
            ex_rt_data_q   <= bus.id_rt_data;
            ex_imm_ext_q   <= ex_imm_ext_d;
            ex_rs_q        <= bus.id_rs;
            ex_rt_q        <= bus.id_rt;
            ex_rd_q        <= bus.id_rd;
            ex_funct_q     <= bus.id_funct;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.stall_out    = load_use & ~bus.branch_out_ex_dm;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_pc        = ex_pc_q;
    assign bus.ex_rs_data   = ex_rs_data_q;
    assign bus.ex_rt_data   = ex_rt_data_q;
    assign bus.ex_imm_ext   = ex_imm_ext_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_funct     = ex_funct_q;
    assign bus.bubble_count = bubble_count_q;
endmodule
